// File: rtl/down_timer_pkg.sv
//------------------------------------------------------------------------------
// down_timer_pkg : shared state encoding and default widths for the timer.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package down_timer_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_PRE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/down_timer_ctrl_tick_prescaler.sv
//------------------------------------------------------------------------------
// tick_prescaler : counts 0..prescale while enabled and pulses tick on the last.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tick_prescaler
  import down_timer_pkg::*;
#(
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  localparam logic [PRE_W-1:0] C_ONE = PRE_W'(1);

  logic [PRE_W-1:0] cnt_q;
  logic [PRE_W-1:0] cnt_d;

  // prescale is compared live, so a new period takes effect mid-count.
  assign tick = en && (cnt_q == prescale);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/down_timer_ctrl.sv
//------------------------------------------------------------------------------
// down_timer_ctrl : programmable countdown timer sequencer with pause,
//                   auto-reload, one-cycle done pulse and sticky irq.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module down_timer_ctrl
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] reload_val,
  input  logic [PRE_W-1:0] prescale,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic             irq
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             irq_q, irq_d;
  logic             done_q;
  logic             expiry;
  logic             tick;

  tick_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (state_q == ST_RUN),
    .clr      (start || stop),
    .prescale (prescale),
    .tick     (tick)
  );

  // Priority: stop, then start, then the per-state behaviour.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    expiry  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_RUN;
      count_d = reload_val;
    end else begin
      case (state_q)
        ST_RUN: begin
          state_d = pause ? ST_PAUSE : ST_RUN;
          if (tick) begin
            if (count_q == '0) begin
              expiry = 1'b1;
              if (auto_reload) begin
                count_d = reload_val;
              end else begin
                state_d = ST_EXPIRED;
              end
            end else begin
              count_d = count_q - C_ONE;
            end
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // A fresh expiry wins over a coincident acknowledge.
  always_comb begin
    irq_d = irq_q;
    if (expiry) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '1;
      irq_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      irq_q   <= irq_d;
      done_q  <= expiry;
    end
  end

  assign count  = count_q;
  assign busy   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign paused = (state_q == ST_PAUSE);
  assign done   = done_q;
  assign irq    = irq_q;

endmodule

`default_nettype wire

// File: doc/down_timer_ctrl.md
Name: down_timer_ctrl

Overview:
- Controller that sequences a WIDTH-bit down counter as a programmable countdown timer.
- Handles load, start, pause, stop, prescaled decrement, terminal-count detection, optional auto-reload and a sticky interrupt.
- Sits beside the counter datapath blocks as their fully synchronous sequencer and exposes a simple control/status interface to a host FSM or register block.

Parameters:
- WIDTH, 4, counter width in bits.
- PRE_W, 8, prescaler width in bits.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; loads reload_val and runs.
- stop  input  1  single-cycle pulse; abort to IDLE.
- pause  input  1  level; freezes counting while high in RUN.
- auto_reload  input  1  level; 1 = periodic mode.
- reload_val  input  WIDTH  start/reload count value.
- prescale  input  PRE_W  decrement period minus 1, in clk cycles.
- irq_ack  input  1  single-cycle pulse; clears irq.
- count  output  WIDTH  current count.
- busy  output  1  high in RUN or PAUSE.
- paused  output  1  high in PAUSE.
- done  output  1  one-cycle pulse at each expiry.
- irq  output  1  sticky expiry flag.

Behaviour:
- Reset is synchronous, active-high, clock clk. Reset values: state IDLE, count all-ones (4'hF at default), prescaler 0, busy 0, paused 0, done 0, irq 0.
- Reset mid-operation aborts immediately; no done pulse.
- States: IDLE, RUN, PAUSE, EXPIRED.
- Tick generation:
  - Prescaler counts 0..prescale in RUN only.
  - tick is asserted when the prescaler equals prescale; the prescaler then wraps to 0.
  - prescale=0 gives a tick every cycle.
  - prescale is sampled live.
- start (IDLE, EXPIRED or RUN): count<=reload_val, prescaler<=0, state<=RUN, effective next cycle. start in RUN restarts the run.
- stop (any state): state<=IDLE, count holds its value, prescaler<=0. stop beats start in the same cycle.
- RUN, tick with count!=0: count<=count-1.
- RUN, tick with count==0 (expiry):
  - done=1 for exactly the following cycle; irq<=1.
  - auto_reload=1: count<=reload_val, stay in RUN.
  - auto_reload=0: state<=EXPIRED, count holds 0.
- Timing: R=reload_val, P=prescale. start sampled at edge N gives count=R at N+1, first decrement at edge N+1+(P+1), and done high (R+1)*(P+1)+1 cycles after the start edge.
- PAUSE:
  - RUN with pause=1 → PAUSE; prescaler and count are frozen.
  - pause=0 → RUN, resuming the prescaler from its frozen value.
  - pause has no effect in IDLE or EXPIRED.
  - start/stop in PAUSE behave as in RUN, and override pause.
  - start while pause=1 goes to RUN, then PAUSE the next cycle.
- irq: set on expiry, cleared by irq_ack. Simultaneous expiry and irq_ack leaves irq=1.
- reload_val=0: expires on the first tick after start. With auto_reload=1 this gives done every P+1 cycles.
- count never wraps below 0. busy and paused are combinational decodes of state.

Decomposition:
- Package down_timer_pkg: state enum (IDLE, RUN, PAUSE, EXPIRED), default WIDTH/PRE_W localparams.
- Sub-module tick_prescaler, instanced once:
  - Inputs: clk, reset, en, clr, prescale.
  - Output: tick.
  - Separates the prescaler from the FSM/count logic.

Test Plan:
- Reset: assert reset 2 cycles → count=4'hF, busy=0, done=0, irq=0.
- One-shot: reload_val=3, prescale=0, auto_reload=0, start → count 3,2,1,0, done pulses once 5 cycles after the start edge, state EXPIRED, irq=1 until irq_ack.
- Prescaled periodic: reload_val=2, prescale=2, auto_reload=1 → each count value held 3 cycles, done every 9 cycles, count reloads to 2 after 0.
- Pause: reload_val=5, prescale=1, pause high for 4 cycles mid-run → count and prescaler frozen, paused=1, total expiry delayed by exactly 4 cycles.
- Stop vs start: assert stop and start in the same cycle during RUN → IDLE, count held, no done. A later start alone restarts from reload_val.
- Boundaries:
  - reload_val=0 with prescale=0, auto_reload=1 → done every cycle.
  - irq_ack coincident with expiry → irq stays 1.
  - Reset during RUN → reset values, no done.
